alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Registered decode stage that sits between fetch and the execute-stage `alu`, producing the 4-bit `alu_ctrl` code the ALU consumes together with operand-select, immediate, register-index and control bits for one RV32I subset instruction per cycle. It is the producer end of the ALU control interface: every `alu_ctrl` encoding the ALU implements is generated here, and nothing else. A single-entry valid/ready pipeline register with flush isolates fetch from execute.

## Interface
- No parameters; widths are fixed by RV32I.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_inst`/`in_pc` valid.
- `in_ready`  out  1  stage can accept; `in_ready = !out_valid || out_ready` (combinational).
- `in_inst`  in  32  instruction word.
- `in_pc`  in  32  instruction address, passed through.
- `flush`  in  1  kill held entry and any instruction offered this cycle.
- `out_valid`  out  1  decoded payload valid.
- `out_ready`  in  1  execute accepts payload.
- `out_pc`  out  32  registered `in_pc`.
- `alu_ctrl`  out  4  ALU op: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0101 NOT.
- `alu_src_imm`  out  1  ALU operand b = `imm` (1) or rs2 data (0).
- `imm`  out  32  sign-extended immediate.
- `rs1`, `rs2`, `rd`  out  5 each  register indices (`inst[19:15]`, `[24:20]`, `[11:7]`).
- `reg_write`, `mem_read`, `mem_write`, `branch`, `branch_ne`  out  1 each  control bits.
- `illegal`  out  1  instruction outside supported subset.

## Operation
- Supported decode (opcode → alu_ctrl, controls):
  - R 0110011: funct7 0000000 + funct3 000 ADD, 110 OR, 111 AND; funct7 0100000 + funct3 000 SUB; `reg_write`=1, `alu_src_imm`=0.
  - I-ALU 0010011: funct3 000 ADD, 110 OR, 111 AND, `alu_src_imm`=1; funct3 100 with `inst[31:20]`=0xFFF (NOT pseudo-op) → NOT, `alu_src_imm`=0; `reg_write`=1.
  - LOAD 0000011 funct3 010: ADD, `alu_src_imm`=1, `mem_read`=1, `reg_write`=1.
  - STORE 0100011 funct3 010: ADD, `alu_src_imm`=1, `mem_write`=1.
  - BRANCH 1100011 funct3 000 (BEQ) / 001 (BNE): SUB, `alu_src_imm`=0, `branch`=1, `branch_ne`=funct3[0]; taken decision uses ALU `zero`.
- Any other encoding: `illegal`=1, `alu_ctrl`=0000, all of `reg_write/mem_read/mem_write/branch/branch_ne/alu_src_imm`=0; entry still issued with `out_valid`=1 so execute can trap.
- Immediate: I/LOAD `{{20{i[31]}},i[31:20]}`; STORE `{{20{i[31]}},i[31:25],i[11:7]}`; BRANCH `{{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}`; R-type and illegal → 0.
- Register indices are copied raw regardless of format.

## Timing
- Reset (async assert, sync-safe deassert on `clk`): `out_valid`=0, all payload outputs 0.
- Accept = `in_valid && in_ready && !flush`; payload loads on accept; `out_valid` set next edge. Latency 1 cycle, throughput 1/cycle with `out_ready` held high.
- Hold: `out_valid && !out_ready` → payload and `out_valid` unchanged; `in_ready`=0.
- Drain without refill: `out_ready && !accept` → `out_valid` cleared; payload holds last value.
- Simultaneous drain and accept: new payload replaces old on same edge, `out_valid` stays 1.
- `flush` has absolute priority: next edge `out_valid`=0 and the instruction offered that cycle is discarded even if `in_ready`=1.
- `rst_n` low mid-stall clears `out_valid` immediately, without waiting for a clock edge.

## Structure
- Shared package `alu_pkg`: `ALU_ADD/SUB/AND/OR/NOT` 4-bit constants, opcode constants (`OP_R`, `OP_IMM`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`), funct3/funct7 constants; the `alu` block imports the same constants.
- One combinational sub-module `alu_ctrl_dec` (instruction → alu_ctrl, control bits, imm, illegal); the top holds only the handshake and pipeline register.

## Test plan
- `0x002081B3` (add x3,x1,x2), out_ready=1 → next cycle out_valid=1, alu_ctrl=0000, rd=3, rs1=1, rs2=2, reg_write=1, illegal=0.
- `0x402081B3` (sub) → alu_ctrl=1000; `0xFFF34293` (not x5,x6) → alu_ctrl=0101, alu_src_imm=0, rd=5, rs1=6.
- `0x00208463` (beq x1,x2,+8) → alu_ctrl=1000, branch=1, branch_ne=0, imm=0x00000008, reg_write=0.
- `0x0020C1B3` (xor) → illegal=1, alu_ctrl=0000, all controls 0, out_valid=1.
- Back-to-back stream with out_ready=0 for 2 cycles → in_ready=0, payload stable; assert flush during stall → out_valid=0 next edge, offered instruction never appears.
- Pull rst_n low while out_valid=1 between edges → out_valid and payload 0 immediately; first accepted instruction after release emerges 1 cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control encodings, RV32I opcode/funct constants and the decoded
// payload record passed from the decoder to the decode-stage register.
package alu_pkg;

  // ALU operation codes consumed by the execute-stage alu
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_NOT = 4'b0101;

  // Major opcodes of the supported subset
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct3 values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_XOR  = 3'b100;  // only legal as the NOT pseudo-op
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // xori rd, rs1, -1 is the NOT pseudo-op
  localparam logic [11:0] IMM_NOT = 12'hFFF;

  // Decoded instruction payload
  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        branch_ne;
    logic        illegal;
  } dec_t;

  // Immediate extractors for the I, S and B formats
  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decoder: instruction word -> ALU control, operand select,
// immediate, register indices and control bits for the RV32I subset.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [31:0] i_inst,
  output dec_t        o_dec
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_ok;

  assign w_opcode = i_inst[6:0];
  assign w_funct3 = i_inst[14:12];
  assign w_funct7 = i_inst[31:25];

  // Decode opcode/funct fields into the payload; unsupported encodings zeroed
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    o_dec     = '0;
    w_ok      = 1'b0;
    o_dec.rs1 = i_inst[19:15];
    o_dec.rs2 = i_inst[24:20];
    o_dec.rd  = i_inst[11:7];

    case (w_opcode)
      OP_R: begin
        o_dec.reg_write = 1'b1;
        if (w_funct7 == F7_BASE) begin
          case (w_funct3)
            F3_ADD: begin w_ok = 1'b1; o_dec.alu_ctrl = ALU_ADD; end
            F3_OR:  begin w_ok = 1'b1; o_dec.alu_ctrl = ALU_OR;  end
            F3_AND: begin w_ok = 1'b1; o_dec.alu_ctrl = ALU_AND; end
            default: w_ok = 1'b0;
          endcase
        end else if (w_funct7 == F7_SUB && w_funct3 == F3_ADD) begin
          w_ok           = 1'b1;
          o_dec.alu_ctrl = ALU_SUB;
        end
      end

      OP_IMM: begin
        o_dec.reg_write   = 1'b1;
        o_dec.imm         = imm_i(i_inst);
        o_dec.alu_src_imm = 1'b1;
        case (w_funct3)
          F3_ADD: begin w_ok = 1'b1; o_dec.alu_ctrl = ALU_ADD; end
          F3_OR:  begin w_ok = 1'b1; o_dec.alu_ctrl = ALU_OR;  end
          F3_AND: begin w_ok = 1'b1; o_dec.alu_ctrl = ALU_AND; end
          F3_XOR: begin
            // The ALU's NOT is unary on operand a, so b is left on rs2
            if (i_inst[31:20] == IMM_NOT) begin
              w_ok              = 1'b1;
              o_dec.alu_ctrl    = ALU_NOT;
              o_dec.alu_src_imm = 1'b0;
            end
          end
          default: w_ok = 1'b0;
        endcase
      end

      OP_LOAD: begin
        w_ok              = (w_funct3 == F3_WORD);
        o_dec.alu_ctrl    = ALU_ADD;
        o_dec.alu_src_imm = 1'b1;
        o_dec.imm         = imm_i(i_inst);
        o_dec.mem_read    = 1'b1;
        o_dec.reg_write   = 1'b1;
      end

      OP_STORE: begin
        w_ok              = (w_funct3 == F3_WORD);
        o_dec.alu_ctrl    = ALU_ADD;
        o_dec.alu_src_imm = 1'b1;
        o_dec.imm         = imm_s(i_inst);
        o_dec.mem_write   = 1'b1;
      end

      OP_BRANCH: begin
        w_ok            = (w_funct3 == F3_BEQ) || (w_funct3 == F3_BNE);
        o_dec.alu_ctrl  = ALU_SUB;
        o_dec.imm       = imm_b(i_inst);
        o_dec.branch    = 1'b1;
        o_dec.branch_ne = w_funct3[0];
      end

      default: w_ok = 1'b0;
    endcase

    // Illegal encodings keep only the raw register indices so execute can trap
    if (!w_ok) begin
      o_dec.alu_ctrl    = ALU_ADD;
      o_dec.alu_src_imm = 1'b0;
      o_dec.imm         = '0;
      o_dec.reg_write   = 1'b0;
      o_dec.mem_read    = 1'b0;
      o_dec.mem_write   = 1'b0;
      o_dec.branch      = 1'b0;
      o_dec.branch_ne   = 1'b0;
    end
    o_dec.illegal = !w_ok;
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage: single-entry valid/ready pipeline register with
// flush, wrapping the combinational alu_ctrl_dec decoder.
module alu_decode_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src_imm,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        branch_ne,
  output logic        illegal
);

  dec_t        w_dec;
  dec_t        r_dec;
  logic [31:0] r_pc;
  logic        r_valid;
  logic        w_accept;

  alu_ctrl_dec u_dec (
    .i_inst (in_inst),
    .o_dec  (w_dec)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  // Valid bit: flush kills, accept fills, downstream consumption drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values,
      // independent of the order the always blocks are evaluated in.
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload register: loads only on accept, otherwise holds the last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec <= '0;
      r_pc  <= '0;
    end else if (w_accept) begin
      r_dec <= w_dec;
      r_pc  <= in_pc;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign alu_ctrl    = r_dec.alu_ctrl;
  assign alu_src_imm = r_dec.alu_src_imm;
  assign imm         = r_dec.imm;
  assign rs1         = r_dec.rs1;
  assign rs2         = r_dec.rs2;
  assign rd          = r_dec.rd;
  assign reg_write   = r_dec.reg_write;
  assign mem_read    = r_dec.mem_read;
  assign mem_write   = r_dec.mem_write;
  assign branch      = r_dec.branch;
  assign branch_ne   = r_dec.branch_ne;
  assign illegal     = r_dec.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: table-driven decode vectors plus
// hand-written stall, flush, drain and mid-cycle reset sequences.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  alu_ctrl;
  logic        alu_src_imm;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write, mem_read, mem_write, branch, branch_ne, illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .alu_ctrl    (alu_ctrl),
    .alu_src_imm (alu_src_imm),
    .imm         (imm),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .branch      (branch),
    .branch_ne   (branch_ne),
    .illegal     (illegal)
  );

  // ctl = {reg_write, mem_read, mem_write, branch, branch_ne, illegal}
  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [3:0]  ctrl;
    logic        src_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  ctl;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] dut_payload();
    return {38'd0, alu_ctrl, alu_src_imm, imm, rs1, rs2, rd,
            reg_write, mem_read, mem_write, branch, branch_ne, illegal, out_pc};
  endfunction

  function automatic logic [127:0] exp_payload(input vec_t v, input logic [31:0] pc);
    return {38'd0, v.ctrl, v.src_imm, v.imm, v.rs1, v.rs2, v.rd, v.ctl, pc};
  endfunction

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{"add",     32'h002081B3, 4'b0000, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd3,  6'b100000};
    vecs[1]  = '{"sub",     32'h402081B3, 4'b1000, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd3,  6'b100000};
    vecs[2]  = '{"not",     32'hFFF34293, 4'b0101, 1'b0, 32'hFFFFFFFF, 5'd6,  5'd31, 5'd5,  6'b100000};
    vecs[3]  = '{"beq",     32'h00208463, 4'b1000, 1'b0, 32'h00000008, 5'd1,  5'd2,  5'd8,  6'b000100};
    vecs[4]  = '{"xor_ill", 32'h0020C1B3, 4'b0000, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd3,  6'b000001};
    vecs[5]  = '{"addi_m1", 32'hFFF00093, 4'b0000, 1'b1, 32'hFFFFFFFF, 5'd0,  5'd31, 5'd1,  6'b100000};
    vecs[6]  = '{"lw",      32'h00812283, 4'b0000, 1'b1, 32'h00000008, 5'd2,  5'd8,  5'd5,  6'b110000};
    vecs[7]  = '{"sw_neg",  32'hFE612E23, 4'b0000, 1'b1, 32'hFFFFFFFC, 5'd2,  5'd6,  5'd28, 6'b001000};
    vecs[8]  = '{"bne_neg", 32'hFE209EE3, 4'b1000, 1'b0, 32'hFFFFFFFC, 5'd1,  5'd2,  5'd29, 6'b000110};
    vecs[9]  = '{"or",      32'h009463B3, 4'b0110, 1'b0, 32'h00000000, 5'd8,  5'd9,  5'd7,  6'b100000};
    vecs[10] = '{"andi",    32'h0F05F513, 4'b0111, 1'b1, 32'h000000F0, 5'd11, 5'd16, 5'd10, 6'b100000};
    vecs[11] = '{"xori_ill",32'h12334293, 4'b0000, 1'b0, 32'h00000000, 5'd6,  5'd3,  5'd5,  6'b000001};
    vecs[12] = '{"blt_ill", 32'h0020C463, 4'b0000, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd8,  6'b000001};
    vecs[13] = '{"and",     32'h0020F1B3, 4'b0111, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd3,  6'b100000};

    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    check("reset_valid", {127'd0, out_valid}, 128'd0);
    check("reset_payload", dut_payload(), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Back-to-back stream, one instruction per cycle, out_ready held high
    for (int i = 0; i < 14; i++) begin
      offer(vecs[i].inst, 32'h1000 + 32'(i * 4));
      step();
      check({vecs[i].name, "_valid"}, {127'd0, out_valid}, 128'd1);
      check(vecs[i].name, dut_payload(), exp_payload(vecs[i], 32'h1000 + 32'(i * 4)));
    end

    // Drain without refill: valid drops, payload holds the last entry
    in_valid = 1'b0;
    step();
    check("drain_valid", {127'd0, out_valid}, 128'd0);
    check("drain_hold", dut_payload(), exp_payload(vecs[13], 32'h1000 + 32'd52));

    // Stall: load add, then hold out_ready low for two cycles while sub is offered
    offer(vecs[0].inst, 32'h2000);
    step();
    check("stall_load", dut_payload(), exp_payload(vecs[0], 32'h2000));
    out_ready = 1'b0;
    offer(vecs[1].inst, 32'h2004);
    #1;
    check("stall_in_ready", {127'd0, in_ready}, 128'd0);
    for (int c = 0; c < 2; c++) begin
      step();
      check("stall_valid", {127'd0, out_valid}, 128'd1);
      check("stall_payload", dut_payload(), exp_payload(vecs[0], 32'h2000));
      check("stall_in_ready2", {127'd0, in_ready}, 128'd0);
    end

    // Flush during stall with in_ready high: offered instruction must be dropped
    out_ready = 1'b1;
    flush = 1'b1;
    offer(vecs[3].inst, 32'h2008);
    #1;
    check("flush_in_ready", {127'd0, in_ready}, 128'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", {127'd0, out_valid}, 128'd0);
    check("flush_no_load", dut_payload(), exp_payload(vecs[0], 32'h2000));
    step();
    check("flush_never_seen", {127'd0, out_valid}, 128'd0);

    // Simultaneous drain and accept: sub replaces or, valid stays high
    offer(vecs[9].inst, 32'h3000);
    step();
    offer(vecs[1].inst, 32'h3004);
    step();
    check("swap_valid", {127'd0, out_valid}, 128'd1);
    check("swap_payload", dut_payload(), exp_payload(vecs[1], 32'h3004));

    // Asynchronous reset mid-stall, between edges
    out_ready = 1'b0;
    offer(vecs[6].inst, 32'h3008);
    step();
    check("pre_rst_valid", {127'd0, out_valid}, 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {127'd0, out_valid}, 128'd0);
    check("async_rst_payload", dut_payload(), 128'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_idle", {127'd0, out_valid}, 128'd0);
    offer(vecs[7].inst, 32'h4000);
    step();
    in_valid = 1'b0;
    check("post_rst_valid", {127'd0, out_valid}, 128'd1);
    v = vecs[7];
    check("post_rst_payload", dut_payload(), exp_payload(v, 32'h4000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
